// File: rtl/alarmclock_pkg.sv
`default_nettype none
// ============================================================================
// alarmclock_pkg : set-mode states and time field limits for the alarm clock
// Revision: 1.0
// ============================================================================
package alarmclock_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    SET_HOURS   = 2'd1,
    SET_MINUTES = 2'd2
  } state_t;

  localparam logic [7:0] HOURS_MAX   = 8'd23;
  localparam logic [7:0] MINUTES_MAX = 8'd59;
  localparam logic [7:0] SECONDS_MAX = 8'd59;

  // Modulo increment of a time field: max_value wraps to zero.
  function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] max_value);
    return (value >= max_value) ? 8'd0 : value + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// tick_prescaler : divides the system clock to a one-second terminal count
// Revision: 1.0
// ============================================================================
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick,
  output logic half
);

  localparam int CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(TICKS_PER_SEC / 2);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  // half is the blink phase of the count entered on the coming edge, so
  // registers loaded from it line up with the counter they describe.
  always_comb begin
    tick         = (r_count == C_LAST);
    w_count_next = (clear || tick) ? '0 : r_count + CNT_W'(1);
    half         = (w_count_next < C_HALF);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
// time_keeper : 24-hour time-of-day counter with button-driven set mode
// Revision: 1.0
// ============================================================================
module time_keeper
  import alarmclock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       hours_enable,
  output logic       minutes_enable,
  output logic       seconds_enable,
  output logic       sec_tick
);

  state_t     r_state;
  state_t     w_state_next;
  logic       w_tick;
  logic       w_half;
  logic       w_leave_set;
  logic       w_run_tick;
  logic       w_inc_hours;
  logic       w_inc_minutes;
  logic [7:0] r_hours;
  logic [7:0] r_minutes;
  logic [7:0] r_seconds;
  logic       r_hours_enable;
  logic       r_minutes_enable;
  logic       r_seconds_enable;
  logic       r_sec_tick;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (w_leave_set),
    .tick   (w_tick),
    .half   (w_half)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // mode_btn has priority: an inc_btn in the same cycle is dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:         if (mode_btn) w_state_next = SET_HOURS;
      SET_HOURS:   if (mode_btn) w_state_next = SET_MINUTES;
      SET_MINUTES: if (mode_btn) w_state_next = RUN;
      default:     w_state_next = RUN;
    endcase
    w_leave_set   = mode_btn && (r_state == SET_MINUTES);
    w_run_tick    = w_tick && (r_state == RUN);
    w_inc_hours   = inc_btn && !mode_btn && (r_state == SET_HOURS);
    w_inc_minutes = inc_btn && !mode_btn && (r_state == SET_MINUTES);
  end

  // Terminal counts outside RUN are dropped, not deferred.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hours    <= '0;
      r_minutes  <= '0;
      r_seconds  <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_run_tick;
      if (w_run_tick) begin
        r_seconds <= wrap_inc(r_seconds, SECONDS_MAX);
        if (r_seconds == SECONDS_MAX) begin
          r_minutes <= wrap_inc(r_minutes, MINUTES_MAX);
          if (r_minutes == MINUTES_MAX) begin
            r_hours <= wrap_inc(r_hours, HOURS_MAX);
          end
        end
      end
      if (w_inc_hours) begin
        r_hours <= wrap_inc(r_hours, HOURS_MAX);
      end
      if (w_inc_minutes) begin
        r_minutes <= wrap_inc(r_minutes, MINUTES_MAX);
      end
      if (w_leave_set) begin
        r_seconds <= '0;
      end
    end
  end

  // Enables follow the state being entered so a field blinks from its first cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hours_enable   <= 1'b1;
      r_minutes_enable <= 1'b1;
      r_seconds_enable <= 1'b1;
    end else begin
      r_hours_enable   <= (w_state_next != SET_HOURS) || w_half;
      r_minutes_enable <= (w_state_next != SET_MINUTES) || w_half;
      r_seconds_enable <= 1'b1;
    end
  end

  assign hours          = r_hours;
  assign minutes        = r_minutes;
  assign seconds        = r_seconds;
  assign hours_enable   = r_hours_enable;
  assign minutes_enable = r_minutes_enable;
  assign seconds_enable = r_seconds_enable;
  assign sec_tick       = r_sec_tick;

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
// tb_time_keeper : self-checking bench for time_keeper against a seconds-of-day model
// Revision: 1.0
// ============================================================================
module tb_time_keeper;

  localparam int TPS = 4;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn  = 1'b0;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       hours_enable;
  logic       minutes_enable;
  logic       seconds_enable;
  logic       sec_tick;

  time_keeper #(
    .TICKS_PER_SEC(TPS)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .mode_btn      (mode_btn),
    .inc_btn       (inc_btn),
    .hours         (hours),
    .minutes       (minutes),
    .seconds       (seconds),
    .hours_enable  (hours_enable),
    .minutes_enable(minutes_enable),
    .seconds_enable(seconds_enable),
    .sec_tick      (sec_tick)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0=run 1=set hours 2=set minutes; time as seconds of day.
  int m_state;
  int m_pc;
  int m_tod;
  bit m_tick;

  logic [27:0] dut_vec;
  assign dut_vec = {hours, minutes, seconds, hours_enable, minutes_enable, seconds_enable, sec_tick};

  function automatic logic [27:0] model_vec();
    logic ph;
    ph = (m_pc < TPS / 2);
    return {8'(m_tod / 3600), 8'((m_tod / 60) % 60), 8'(m_tod % 60),
            (m_state != 1) || ph, (m_state != 2) || ph, 1'b1, m_tick};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_tod   = 0;
    m_tick  = 1'b0;
  endtask

  task automatic model_edge(input bit mb, input bit inc);
    bit tk;
    int h, mi, s;
    tk = (m_pc == TPS - 1);
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s  = m_tod % 60;
    m_tick = 1'b0;
    if (m_state == 0 && tk) begin
      m_tod  = (m_tod + 1) % 86400;
      m_tick = 1'b1;
    end else if (m_state == 1 && inc && !mb) begin
      m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
    end else if (m_state == 2 && inc && !mb) begin
      m_tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
    end
    m_pc = tk ? 0 : m_pc + 1;
    if (mb) begin
      if (m_state == 2) begin
        m_tod = m_tod - (m_tod % 60);
        m_pc  = 0;
      end
      m_state = (m_state + 1) % 3;
    end
  endtask

  task automatic step(input bit mb, input bit inc);
    mode_btn = mb;
    inc_btn  = inc;
    @(posedge clock);
    model_edge(mb, inc);
    #1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic to_run();
    for (int k = 0; k < 3 && m_state != 0; k++) step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    n_vec++;
    if (dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL reset: got %h want %h", dut_vec, model_vec());
    end
    reset_n = 1'b1;
  endtask

  task automatic test_run();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL run[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_rollover();
    to_run();
    step(1'b1, 1'b0);
    for (int i = 0; i < 24 && (m_tod / 3600) != 23; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 60 && ((m_tod / 60) % 60) != 59; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 400 && m_tod != 86398; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL rollover[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_set_hours();
    to_run();
    step(1'b1, 1'b0);
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b1);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL set_hours[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_set_minutes();
    to_run();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 61; i++) begin
      step(1'b0, 1'b1);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL set_minutes[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_leave_set();
    to_run();
    for (int i = 0; i < 400 && (m_tod % 60) != 37; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(i == 0, 1'b0);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL leave_set[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_same_cycle();
    to_run();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL same_cycle[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    to_run();
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL reset_mid async: got %h want %h", dut_vec, model_vec());
    end
    @(posedge clock);
    #1;
    n_vec++;
    if (dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL reset_mid held: got %h want %h", dut_vec, model_vec());
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL reset_mid run[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_rollover();
    test_set_hours();
    test_set_minutes();
    test_leave_set();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/time_keeper.md
# time_keeper

Time-of-day counter for the alarm clock, directly upstream of the two-digit seven-segment display stages. It divides the system clock down to a one-second tick and keeps hours (0–23), minutes (0–59) and seconds (0–59) as 8-bit binary values. It also implements a three-state set mode driven by debounced button pulses. For each field it produces one 8-bit value and one enable; the display stage consumes both directly, so the field being set blinks.

## Interface
- TICKS_PER_SEC, default 50_000_000: system clock cycles per second. Must be even and ≥ 2.
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mode_btn  in  1  single-cycle pulse, already debounced and synchronised; advances set mode.
- inc_btn  in  1  single-cycle pulse, already debounced and synchronised; increments the field being set.
- hours  out  8  binary 0–23, upper bits zero.
- minutes  out  8  binary 0–59.
- seconds  out  8  binary 0–59.
- hours_enable  out  1  display enable for hours.
- minutes_enable  out  1  display enable for minutes.
- seconds_enable  out  1  display enable for seconds.
- sec_tick  out  1  one-cycle pulse per elapsed second in RUN.

## Operation
- States: RUN, SET_HOURS, SET_MINUTES.
- mode_btn transitions: RUN→SET_HOURS→SET_MINUTES→RUN.
- RUN: time advances on each prescaler terminal count.
  - seconds 59→0 carries into minutes.
  - minutes 59→0 carries into hours.
  - hours 23→0.
  - 23:59:59 rolls to 00:00:00 in a single edge.
- SET_HOURS: time is frozen. Each inc_btn gives hours+1, with 23→0. No other field changes.
- SET_MINUTES: time is frozen. Each inc_btn gives minutes+1, with 59→0. No carry into hours.
- Leaving SET_MINUTES for RUN: seconds←0 and prescaler←0, so the first second after setting is a full second.
- Enables:
  - In RUN, all three enables are 1.
  - In a set state, the enable of the field being set equals blink phase. The other two enables are 1.
  - Blink phase is 1 while prescaler < TICKS_PER_SEC/2, else 0, giving a 1 Hz blink with 50 % duty.
- The prescaler free-runs in all states. It is cleared only by reset and on the SET_MINUTES→RUN transition.
- mode_btn and inc_btn in the same cycle: mode_btn wins and inc_btn is ignored.
- inc_btn in RUN is ignored.
- Reset values:
  - state RUN, time 00:00:00, prescaler 0.
  - all enables 1, sec_tick 0.

## Timing
- Prescaler counts 0..TICKS_PER_SEC−1 and wraps.
- Terminal count: prescaler == TICKS_PER_SEC−1.
- On the edge that wraps the prescaler in RUN:
  - the time registers update;
  - sec_tick goes high for exactly one cycle.
  - Zero additional latency: both become visible together.
- First sec_tick after reset occurs TICKS_PER_SEC edges after reset release.
- sec_tick is never asserted outside RUN. A terminal count in a set state is discarded; it is not deferred.
- Button response: state or field updates on the same edge the pulse is sampled, so outputs are visible one cycle after the pulse.
- Enables are registered and change on the edge where prescaler crosses 0 or TICKS_PER_SEC/2, or on a state change.
- Reset asserted mid-operation: all registers return to reset values immediately, independent of clock.

## Structure
- Shared package alarmclock_pkg:
  - state enum {RUN, SET_HOURS, SET_MINUTES};
  - constants HOURS_MAX=23, MINUTES_MAX=59, SECONDS_MAX=59.
  - The display stage and the later alarm-compare block import the same constants.
- Sub-module tick_prescaler(TICKS_PER_SEC):
  - ports clock, reset_n, clear;
  - outputs tick and half (blink phase).
  - Counter width is $clog2(TICKS_PER_SEC).
- time_keeper holds the FSM, the three field counters with carry chain, and the enable registers.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset release, run 12 cycles → sec_tick pulses on cycles 4, 8, 12; seconds reads 1, 2, 3; all enables stay 1.
- Preload 23:59:58 via set mode, run 2 ticks → 23:59:59 then 00:00:00 on a single edge; minutes and hours wrap in the same cycle as seconds.
- mode_btn once, then inc_btn ×25 → state SET_HOURS; hours ends at 1 (wrapped at 23→0); seconds frozen; hours_enable toggles 1,1,0,0 per cycle; other enables stay 1; no sec_tick.
- mode_btn ×2, then inc_btn ×61 → minutes ends at 1; hours unchanged (no carry); minutes_enable blinks.
- From SET_MINUTES with seconds=37, pulse mode_btn → RUN; seconds=0; first sec_tick exactly 4 cycles later.
- mode_btn and inc_btn in the same cycle in RUN → state SET_HOURS, hours unchanged. Reset asserted mid-set → 00:00:00, RUN, all enables 1 asynchronously.
